// File: rtl/sevenseg_scanner.sv
// Purpose: time-multiplexed driver for a 4-digit common-anode 7-segment display, blanked dead-time per slot.
// Latency: pins are registered and reflect the previous cycle's slot/digit counters; frame_o follows the latch cycle.
// Backpressure: none; free-running scan, inputs are sampled only at frame start into shadow registers.
module sevenseg_scanner #(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int DIGIT_HZ    = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic [3:0]  en_i,
    input  logic [3:0]  dp_i,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_o
);

    localparam int SLOT_CYCLES = CLK_FREQ / DIGIT_HZ;
    localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_START = CW'(DEAD_CYCLES);

    // A dead-time that swallows the whole slot would never light anything.
    if (DEAD_CYCLES >= SLOT_CYCLES) begin : g_bad_dead
        $error("DEAD_CYCLES must be smaller than CLK_FREQ/DIGIT_HZ");
    end

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    // With no dead-time the slot starts lit.
    localparam phase_t PHASE_AT_WRAP = (DEAD_CYCLES == 0) ? PH_ON : PH_BLANK;

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    phase_t        phase_q, phase_d;
    logic [15:0]   shadow_value_q;
    logic [3:0]    shadow_en_q;
    logic [3:0]    shadow_dp_q;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          dp_d;
    logic          frame_start;
    logic          slot_wrap;
    logic          lit;
    logic [3:0]    nibble;

    // Active-low {g..a} glyph for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Next-state for counters and phase, plus the pin values implied by the current state.
    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        frame_start = (slot_cnt_q == '0) && (digit_idx_q == 2'd0);

        phase_d = phase_q;
        if (slot_wrap) begin
            phase_d = PHASE_AT_WRAP;
        end else if (slot_cnt_d == DEAD_START) begin
            phase_d = PH_ON;
        end

        nibble = 4'(shadow_value_q >> {digit_idx_q, 2'b00});
        lit    = (phase_q == PH_ON) && shadow_en_q[digit_idx_q];

        seg_d = 7'h7F;
        an_d  = 4'hF;
        dp_d  = 1'b1;
        if (lit) begin
            seg_d = hex7(nibble);
            an_d  = ~(4'b0001 << digit_idx_q);
            dp_d  = ~shadow_dp_q[digit_idx_q];
        end
    end

    // Scan counters, phase FSM, frame shadow latch and registered pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q     <= '0;
            digit_idx_q    <= 2'd0;
            phase_q        <= PHASE_AT_WRAP;
            shadow_value_q <= 16'h0000;
            shadow_en_q    <= 4'h0;
            shadow_dp_q    <= 4'h0;
            seg            <= 7'h7F;
            an             <= 4'hF;
            dp             <= 1'b1;
            frame_o        <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            phase_q     <= phase_d;
            if (frame_start) begin
                shadow_value_q <= value_i;
                shadow_en_q    <= en_i;
                shadow_dp_q    <= dp_i;
            end
            seg     <= seg_d;
            an      <= an_d;
            dp      <= dp_d;
            frame_o <= frame_start;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Purpose: scoreboard bench for sevenseg_scanner against a cycle-indexed reference model.
// Latency: each prediction is queued before the edge it describes and checked 1 time unit after it.
// Backpressure: none; the monitor pops one expectation per clock while the queue is non-empty.
module tb_sevenseg_scanner;

    localparam int SLOT = 10;
    localparam int DEAD = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       frame;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_i;
    logic [3:0]  en_i;
    logic [3:0]  dp_i;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_o;

    int compared   = 0;
    int mismatched = 0;

    out_t       exp_q[$];
    logic [6:0] hex_tbl [16];

    // Reference model state: cycles since reset release, plus the frame snapshot.
    int          m_t = 0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_en  = 4'h0;
    logic [3:0]  m_dp  = 4'h0;

    sevenseg_scanner #(
        .CLK_FREQ   (1000),
        .DIGIT_HZ   (100),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value_i(value_i),
        .en_i   (en_i),
        .dp_i   (dp_i),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    // Predict what the pins show after the coming edge, given the inputs now applied.
    task automatic predict();
        out_t e;
        int   slot;
        int   idx;
        bit   on;
        e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1, frame: 1'b0};
        if (!rst_n) begin
            m_t   = 0;
            m_val = 16'h0;
            m_en  = 4'h0;
            m_dp  = 4'h0;
        end else begin
            slot = m_t % SLOT;
            idx  = (m_t / SLOT) % 4;
            on   = (slot >= DEAD) && m_en[idx];
            if (on) begin
                e.seg     = hex_tbl[m_val[idx*4 +: 4]];
                e.an[idx] = 1'b0;
                e.dp      = !m_dp[idx];
            end
            if (m_t % (4 * SLOT) == 0) begin
                e.frame = 1'b1;
                m_val   = value_i;
                m_en    = en_i;
                m_dp    = dp_i;
            end
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            predict();
            @(negedge clk);
        end
    endtask

    // Monitor: compare every output against the queued expectation, and check anode exclusivity.
    initial begin
        out_t got;
        out_t want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{seg: seg, an: an, dp: dp, frame: frame_o};
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL pins t=%0t: got seg=%b an=%b dp=%b frame=%b, want seg=%b an=%b dp=%b frame=%b",
                             $time, got.seg, got.an, got.dp, got.frame,
                             want.seg, want.an, want.dp, want.frame);
                end
                compared++;
                if (!$onehot0(~an)) begin
                    mismatched++;
                    $display("FAIL anode_onehot t=%0t: an=%b, want at most one low", $time, an);
                end
            end
        end
    end

    initial begin
        hex_tbl[0]  = 7'b1000000; hex_tbl[1]  = 7'b1111001;
        hex_tbl[2]  = 7'b0100100; hex_tbl[3]  = 7'b0110000;
        hex_tbl[4]  = 7'b0011001; hex_tbl[5]  = 7'b0010010;
        hex_tbl[6]  = 7'b0000010; hex_tbl[7]  = 7'b1111000;
        hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0010000;
        hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
        hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001;
        hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;

        // Reset held for 5 cycles.
        rst_n   = 1'b0;
        value_i = 16'h1234;
        en_i    = 4'hF;
        dp_i    = 4'h0;
        cycle(5);

        // First frame 1,2,3,4; mid-frame change must not show until next frame.
        rst_n = 1'b1;
        cycle(15);
        value_i = 16'hABCD;
        cycle(25 + 40);

        // Sparse enables and decimal points.
        en_i = 4'b0101;
        dp_i = 4'b0100;
        cycle(80);

        // Sweep every hex glyph, one per frame, all digits enabled.
        en_i = 4'hF;
        for (int k = 0; k < 16; k++) begin
            value_i = {4{4'(k)}} ^ 16'(k << 4);
            dp_i    = 4'($urandom_range(0, 15));
            cycle(40);
        end

        // Fresh reset, then a one-cycle reset pulse mid-slot of digit 2.
        rst_n = 1'b0;
        cycle(1);
        rst_n   = 1'b1;
        value_i = 16'h5A3C;
        cycle(25);
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
        cycle(50);

        // Random inputs every cycle with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            value_i = 16'($urandom);
            en_i    = 4'($urandom_range(0, 15));
            dp_i    = 4'($urandom_range(0, 15));
            cycle(1);
        end

        // Drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
